// File: rtl/btn_debounce_if.sv
// Debouncer signal bundle: raw pin levels in, conditioned level plus edge pulses out.
interface btn_debounce_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] btn_in;
  logic [WIDTH-1:0] btn_clean;
  logic [WIDTH-1:0] btn_rise;
  logic [WIDTH-1:0] btn_fall;

  modport master (output btn_in, input btn_clean, input btn_rise, input btn_fall);
  modport slave  (input btn_in, output btn_clean, output btn_rise, output btn_fall);
endinterface

// File: rtl/btn_debounce.sv
// Per-channel button debouncer: 2-flop synchronizer, stability counter, registered
// clean level and single-cycle rise/fall pulses.
module btn_debounce #(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic           clk,
  input  logic           rst_n,
  btn_debounce_if.slave  bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Implicit per-channel FSM: the state is simply whether s2 disagrees with the clean level.
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  logic [WIDTH-1:0]            s1_r;
  logic [WIDTH-1:0]            s2_r;
  logic [WIDTH-1:0]            clean_r;
  logic [WIDTH-1:0]            rise_r;
  logic [WIDTH-1:0]            fall_r;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0]            state_s;
  logic [WIDTH-1:0]            clean_nxt_s;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt_s;

  assign state_s = s2_r ^ clean_r;

  // Next counter and clean level; any return to the clean level drops the partial count.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    clean_nxt_s = clean_r;
    for (int i = 0; i < WIDTH; i++) begin
      case (state_s[i])
        ST_IDLE: begin
          cnt_nxt_s[i] = CNT_ZERO;
        end
        ST_COUNTING: begin
          if (cnt_r[i] == CNT_LAST) begin
            clean_nxt_s[i] = s2_r[i];
            cnt_nxt_s[i]   = CNT_ZERO;
          end else begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
          end
        end
        default: begin
          cnt_nxt_s[i] = CNT_ZERO;
        end
      endcase
    end
  end

  // State registers; pulses are derived from the clean-level update so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r    <= {WIDTH{1'b0}};
      s2_r    <= {WIDTH{1'b0}};
      cnt_r   <= {WIDTH{CNT_ZERO}};
      clean_r <= {WIDTH{1'b0}};
      rise_r  <= {WIDTH{1'b0}};
      fall_r  <= {WIDTH{1'b0}};
    end else begin
      s1_r    <= bus.btn_in;
      s2_r    <= s1_r;
      cnt_r   <= cnt_nxt_s;
      clean_r <= clean_nxt_s;
      rise_r  <= clean_nxt_s & ~clean_r;
      fall_r  <= ~clean_nxt_s & clean_r;
    end
  end

  assign bus.btn_clean = clean_r;
  assign bus.btn_rise  = rise_r;
  assign bus.btn_fall  = fall_r;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: a sample-history reference model feeds a
// scoreboard queue, and each scenario task checks its own latency and pulse counts.
module tb_btn_debounce;

  localparam int WIDTH  = 2;
  localparam int STABLE = 4;

  typedef struct packed {
    logic [1:0] clean;
    logic [1:0] rise;
    logic [1:0] fall;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic y;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  obs_t sb_q[$];

  // Reference model: clean flips once the last STABLE synchronized samples all oppose it.
  logic [1:0]        m_p1 = 2'b00;
  logic [1:0]        m_p2 = 2'b00;
  logic [1:0]        m_clean = 2'b00;
  logic [STABLE-1:0] m_hist [WIDTH];

  always #5 clk = ~clk;

  btn_debounce_if #(.WIDTH(WIDTH)) bus ();

  btn_debounce #(.WIDTH(WIDTH), .STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Downstream 2-input AND gate fed directly from the clean levels.
  assign y = bus.btn_clean[0] & bus.btn_clean[1];

  task automatic model_push(input logic [1:0] din, input logic rst_v);
    obs_t       e;
    logic [1:0] s2_used;
    logic [1:0] nc;
    e = '0;
    if (!rst_v) begin
      m_p1    = 2'b00;
      m_p2    = 2'b00;
      m_clean = 2'b00;
      for (int i = 0; i < WIDTH; i++) m_hist[i] = '0;
    end else begin
      s2_used = m_p2;
      m_p2    = m_p1;
      m_p1    = din;
      nc      = m_clean;
      for (int i = 0; i < WIDTH; i++) begin
        m_hist[i] = {m_hist[i][STABLE-2:0], s2_used[i]};
        if (m_hist[i] == {STABLE{~m_clean[i]}}) nc[i] = ~m_clean[i];
      end
      e.clean = nc;
      e.rise  = nc & ~m_clean;
      e.fall  = ~nc & m_clean;
      m_clean = nc;
    end
    sb_q.push_back(e);
  endtask

  // Drive one cycle, push the model's expectation, then pop it against the sampled outputs.
  task automatic tick(input logic [1:0] din, input logic rst_v, output obs_t got, output obs_t exp);
    bus.btn_in = din;
    rst_n      = rst_v;
    model_push(din, rst_v);
    @(posedge clk);
    #1;
    cyc++;
    got = {bus.btn_clean, bus.btn_rise, bus.btn_fall};
    exp = sb_q.pop_front();
  endtask

  task automatic test_reset;
    obs_t got, exp;
    int first;
    first = -1;
    for (int k = 0; k < 3; k++) begin
      tick(2'b11, 1'b0, got, exp);
      checks++;
      if (got !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b want=%b", cyc, got, 6'b0);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      tick(2'b11, 1'b1, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%b want=%b", cyc, got, exp);
      end
      if (first < 0 && got.clean == 2'b11) first = k;
      if (k == 6) begin
        checks++;
        if (got.rise !== 2'b11) begin
          errors++;
          $display("FAIL reset_rise cyc=%0d got=%b want=%b", cyc, got.rise, 2'b11);
        end
      end
      if (k == 7) begin
        checks++;
        if (got.rise !== 2'b00) begin
          errors++;
          $display("FAIL reset_rise_len cyc=%0d got=%b want=%b", cyc, got.rise, 2'b00);
        end
      end
    end
    checks++;
    if (first !== 6) begin
      errors++;
      $display("FAIL reset_latency got=%0d want=%0d", first, 6);
    end
  endtask

  task automatic test_step;
    obs_t got, exp;
    int first, rises;
    first = -1;
    rises = 0;
    for (int k = 0; k < 8; k++) begin
      tick(2'b00, 1'b1, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL step_settle cyc=%0d got=%b want=%b", cyc, got, exp);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      tick(2'b01, 1'b1, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL step cyc=%0d got=%b want=%b", cyc, got, exp);
      end
      if (first < 0 && got.clean[0]) first = k;
      if (got.rise[0]) rises++;
    end
    checks++;
    if (first !== 6) begin
      errors++;
      $display("FAIL step_latency got=%0d want=%0d", first, 6);
    end
    checks++;
    if (rises !== 1) begin
      errors++;
      $display("FAIL step_rise_count got=%0d want=%0d", rises, 1);
    end
  endtask

  task automatic test_bounce;
    obs_t got, exp;
    logic [5:0] pat;
    int first, rises, falls;
    pat   = 6'b101101;
    first = -1;
    rises = 0;
    falls = 0;
    for (int k = 0; k < 16; k++) begin
      tick({(k < 6) ? pat[5-k] : 1'b1, 1'b1}, 1'b1, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bounce cyc=%0d got=%b want=%b", cyc, got, exp);
      end
      if (first < 0 && got.clean[1]) first = k;
      if (got.rise[1]) rises++;
      if (got.fall[1]) falls++;
    end
    checks++;
    if (first !== 10) begin
      errors++;
      $display("FAIL bounce_latency got=%0d want=%0d", first, 10);
    end
    checks++;
    if (rises !== 1 || falls !== 0) begin
      errors++;
      $display("FAIL bounce_pulses got=%0d/%0d want=1/0", rises, falls);
    end
  endtask

  task automatic test_glitch;
    obs_t got, exp;
    int pulses;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick(2'b00, 1'b1, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL glitch_settle cyc=%0d got=%b want=%b", cyc, got, exp);
      end
    end
    for (int k = 0; k < 10; k++) begin
      tick((k < 3) ? 2'b01 : 2'b00, 1'b1, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL glitch cyc=%0d got=%b want=%b", cyc, got, exp);
      end
      if (got.clean[0] || got.rise[0] || got.fall[0]) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL glitch_leak got=%0d want=%0d", pulses, 0);
    end
    checks++;
    if (dut.cnt_r[0] !== 2'd0) begin
      errors++;
      $display("FAIL glitch_cnt got=%0d want=%0d", dut.cnt_r[0], 0);
    end
  endtask

  task automatic test_reset_mid;
    obs_t got, exp;
    int first;
    first = -1;
    for (int k = 0; k < 5; k++) begin
      tick(2'b01, 1'b1, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_count cyc=%0d got=%b want=%b", cyc, got, exp);
      end
    end
    checks++;
    if (dut.cnt_r[0] !== 2'd3) begin
      errors++;
      $display("FAIL mid_cnt got=%0d want=%0d", dut.cnt_r[0], 3);
    end
    tick(2'b01, 1'b0, got, exp);
    checks++;
    if (got !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset cyc=%0d got=%b want=%b", cyc, got, 6'b0);
    end
    for (int k = 1; k <= 8; k++) begin
      tick(2'b01, 1'b1, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_release cyc=%0d got=%b want=%b", cyc, got, exp);
      end
      if (first < 0 && got.clean[0]) first = k;
    end
    checks++;
    if (first !== 6) begin
      errors++;
      $display("FAIL mid_latency got=%0d want=%0d", first, 6);
    end
  endtask

  task automatic test_gate_sweep;
    obs_t got, exp;
    logic [1:0] pats [4];
    pats[0] = 2'b00;
    pats[1] = 2'b01;
    pats[2] = 2'b10;
    pats[3] = 2'b11;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 10; k++) begin
        tick(pats[p], 1'b1, got, exp);
        checks++;
        if (got !== exp || y !== (exp.clean[0] & exp.clean[1])) begin
          errors++;
          $display("FAIL gate cyc=%0d got=%b y=%b want=%b y=%b", cyc, got, y, exp,
                   exp.clean[0] & exp.clean[1]);
        end
      end
      checks++;
      if (y !== (pats[p] == 2'b11)) begin
        errors++;
        $display("FAIL gate_final pat=%b got=%b want=%b", pats[p], y, pats[p] == 2'b11);
      end
    end
  endtask

  initial begin
    bus.btn_in = 2'b11;
    for (int i = 0; i < WIDTH; i++) m_hist[i] = '0;
    test_reset();
    test_step();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_gate_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditions raw push-button or switch inputs before they drive the combinational gate stage (the 2-input gates' a/b inputs).
- Per channel: 2-flop synchronizer, then a stability counter. Produces a clean level plus single-cycle rise/fall pulses.
- Sits between the board I/O pins and the gate modules in every board-level top of the exercise set.

Parameters:
WIDTH, 2, number of independent input channels (one per gate input)
STABLE_CYCLES, 500000, consecutive synchronized cycles a new level must hold before it is accepted; legal range >= 2 (10 ms at 50 MHz)
CNT_W, $clog2(STABLE_CYCLES), counter width; derived, never overridden

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  reset; synchronous and active-low
btn_in  input  WIDTH  raw asynchronous inputs from pins (may bounce)
btn_clean  output  WIDTH  debounced level per channel; feeds gate inputs
btn_rise  output  WIDTH  1-cycle pulse when btn_clean goes 0->1
btn_fall  output  WIDTH  1-cycle pulse when btn_clean goes 1->0

Behaviour:
- Reset: rst_n sampled low on a clk edge clears all state:
  - sync flops = 0, counters = 0
  - btn_clean = 0, btn_rise = 0, btn_fall = 0
  - Asserting rst_n mid-count discards the count; no pulse is emitted on reset entry or exit.
- Synchronizer, per channel i:
  - s1[i] <= btn_in[i]; s2[i] <= s1[i].
  - Only s2 is used downstream; btn_in is never read combinationally.
- Stability counter, per channel, fully independent:
  - If s2[i] == btn_clean[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_CYCLES-1: btn_clean[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
  - The counter never wraps; it saturates only by the accept rule above.
- Implicit 2-state FSM per channel: IDLE (cnt=0, s2==clean) and COUNTING (s2!=clean).
  - Any return of s2 to the clean level during COUNTING goes back to IDLE with cnt=0.
  - The partial count is not preserved.
- Latency:
  - A clean step on btn_in that lands just before clk edge k reaches s2 at edge k+1.
  - btn_clean changes at edge k+1+STABLE_CYCLES.
  - Total is STABLE_CYCLES+2 edges counted from the first sampling edge (edge k).
- Glitch rejection: any excursion of s2 lasting < STABLE_CYCLES cycles never reaches btn_clean.
- Pulses:
  - btn_rise[i] and btn_fall[i] are registered and high for exactly the one cycle following the edge where btn_clean[i] changed.
  - Rise and fall are never both high on the same channel.
  - Different channels may pulse in the same cycle.
- Simultaneous changes on several channels are handled independently with identical timing.
- All outputs are registered; no combinational path from btn_in to any output.

Test Plan:
- Bench uses WIDTH=2, STABLE_CYCLES=4. Hold rst_n=0 for 3 cycles with btn_in=2'b11, then release. Required: btn_clean=00 and no pulses while in reset; btn_clean=11 exactly 6 edges after release; btn_rise=11 for 1 cycle only.
- After reset with btn_in=00, step btn_in[0] to 1 and hold. Required: btn_clean[0] rises on the 6th edge after the step; btn_rise[0] is high for exactly one cycle; btn_clean[1] stays 0.
- Bounce pattern on btn_in[1]: 1,0,1,1,0,1, one cycle each, then steady 1. Required: btn_clean[1] does not change until s2 has held 1 for 4 cycles; exactly one btn_rise[1] pulse; no btn_fall[1].
- Glitch of 3 cycles high on btn_in[0], then back to 0. Required: btn_clean[0] stays 0, no pulses, and cnt returns to 0.
- Pull rst_n low for 1 cycle while channel 0 is at cnt=3 (mid-debounce). Required: all outputs 0 on the next edge and no pulse emitted. After release, the input still high yields a full 6-edge latency again.
- Feed btn_clean into an and_gate instance and sweep 00, 01, 10, 11, each held 10 cycles. Required: the gate output y=1 only for the 11 case, and it follows btn_clean with zero additional cycles of latency.
